pulse_width_meter: RTL and testbench

Receive-side companion to the one-shot timer. It measures the high time of an incoming pulse, in clock cycles, and reports the width with a one-cycle strobe. It also flags whether the width falls inside a tolerance window around the nominal 1 s (50,000,000-cycle) target. It sits downstream of any one-shot output, as a checker or consumer of pulse width.

---
 rtl/pulse_width_meter_pkg.sv | 27 ++
 rtl/pulse_width_meter_sync_edge_detect.sv | 52 +++++
 rtl/pulse_width_meter.sv | 174 +++++++++++++++++
 tb/tb_pulse_width_meter.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/pulse_width_meter_pkg.sv
// Shared pulse definitions: FSM state encodings, the one-second cycle count
// used by both the one-shot timer and this meter, and the tolerance-window
// lower-bound helper.
package pulse_width_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    REPORT  = 2'd2
  } state_e;

  // Nominal 1 s at 50 MHz; also the one-shot timer's terminal count.
  localparam int ONE_SECOND_CYCLES = 32'sd50000000;

  // Lower edge of the tolerance window, clamped at zero so a tolerance
  // wider than the target never wraps to a huge unsigned bound.
  function automatic int window_lower(input int target, input int tol);
    int lower;
    if (tol > target) begin
      lower = 32'sd0;
    end else begin
      lower = target - tol;
    end
    return lower;
  endfunction

endpackage

// File: rtl/pulse_width_meter_sync_edge_detect.sv
// sync_edge_detect: two-flop synchronizer for an asynchronous input plus a
// history flop, giving the synchronized level and single-cycle rise/fall
// pulses. All three flops reset to RESET_VAL, so an input already at that
// level when reset releases produces no edge.
//
// Ports:
//   clock    in   rising-edge clock
//   reset_l  in   asynchronous active-low reset
//   async_in in   raw asynchronous input
//   s_in     out  synchronized level
//   rise     out  s_in went 0->1 this cycle
//   fall     out  s_in went 1->0 this cycle
module sync_edge_detect #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset_l,
  input  logic async_in,
  output logic s_in,
  output logic rise,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic hist_q, hist_d;

  // Next-state of the shift chain: pin -> meta -> sync -> history.
  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
    hist_d = sync_q;
  end

  // Synchronizer and history registers.
  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
      hist_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign s_in = sync_q;
  assign rise = sync_q & ~hist_q;
  assign fall = ~sync_q & hist_q;

endmodule

// File: rtl/pulse_width_meter.sv
// pulse_width_meter: measures the high time of pulse_in in clock cycles,
// reports it with a one-cycle width_valid strobe, and flags whether the
// width lies inside [TARGET-TOL, TARGET+TOL]. The counter saturates at
// all-ones and the saturation is reported through overflow.
//
// Ports:
//   clock        in   rising-edge clock
//   reset_l      in   asynchronous active-low reset
//   pulse_in     in   pulse under measurement (may be asynchronous)
//   clear        in   synchronous abort/clear, active-high
//   width        out  last measured high time (cycles)
//   width_valid  out  one-cycle strobe when width/in_range/overflow update
//   in_range     out  last width within the window and not saturated
//   overflow     out  last measurement saturated the counter
//   busy         out  measurement in progress
module pulse_width_meter
  import pulse_width_meter_pkg::*;
#(
  parameter int CNT_W  = 26,
  parameter int TARGET = ONE_SECOND_CYCLES,
  parameter int TOL    = 1000
) (
  input  logic             clock,
  input  logic             reset_l,
  input  logic             pulse_in,
  input  logic             clear,
  output logic [CNT_W-1:0] width,
  output logic             width_valid,
  output logic             in_range,
  output logic             overflow,
  output logic             busy
);

  // Window bounds are compared one bit wider than the counter so that
  // TARGET+TOL may exceed the counter range without wrapping.
  localparam logic [CNT_W:0]   LOWER   = (CNT_W+1)'(window_lower(TARGET, TOL));
  localparam logic [CNT_W:0]   UPPER   = (CNT_W+1)'(TARGET + TOL);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic s_in, rise, fall;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             sat_q, sat_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic             in_range_q, in_range_d;
  logic             overflow_q, overflow_d;
  logic             width_valid_q, width_valid_d;
  logic             busy_q, busy_d;
  logic [CNT_W:0]   count_ext;
  logic             win_ok;

  // Reset value 1 keeps a pin that is already high at reset release from
  // looking like a fresh rise.
  sync_edge_detect #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clock    (clock),
    .reset_l  (reset_l),
    .async_in (pulse_in),
    .s_in     (s_in),
    .rise     (rise),
    .fall     (fall)
  );

  // Window check on the count being latched at the fall.
  always_comb begin
    count_ext = {1'b0, count_q};
    win_ok    = (count_ext >= LOWER) && (count_ext <= UPPER) && !sat_q;
  end

  // Next-state, counter and result logic.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    sat_d      = sat_q;
    width_d    = width_q;
    in_range_d = in_range_q;
    overflow_d = overflow_q;

    if (clear) begin
      state_d    = IDLE;
      count_d    = {CNT_W{1'b0}};
      sat_d      = 1'b0;
      width_d    = {CNT_W{1'b0}};
      in_range_d = 1'b0;
      overflow_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise) begin
            // The rise cycle itself is the first high cycle.
            count_d = CNT_ONE;
            state_d = MEASURE;
          end else begin
            state_d = IDLE;
          end
        end
        MEASURE: begin
          if (fall) begin
            // Count already equals the number of high cycles; no increment.
            width_d    = count_q;
            overflow_d = sat_q;
            in_range_d = win_ok;
            state_d    = REPORT;
          end else if (s_in) begin
            if (count_q == CNT_MAX) begin
              sat_d = 1'b1;
            end else begin
              count_d = count_q + CNT_ONE;
              if (count_q == (CNT_MAX - CNT_ONE)) begin
                sat_d = 1'b1;
              end else begin
                sat_d = sat_q;
              end
            end
          end else begin
            state_d = MEASURE;
          end
        end
        REPORT: begin
          sat_d = 1'b0;
          // A rise here means a one-cycle low gap; start the next pulse
          // immediately so back-to-back pulses are not lost.
          if (rise) begin
            count_d = CNT_ONE;
            state_d = MEASURE;
          end else begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    // Strobe and busy are registered copies of the next state so they line
    // up exactly with the state register.
    width_valid_d = (state_d == REPORT);
    busy_d        = (state_d == MEASURE);
  end

  // State, counter and output registers.
  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      state_q       <= IDLE;
      count_q       <= {CNT_W{1'b0}};
      sat_q         <= 1'b0;
      width_q       <= {CNT_W{1'b0}};
      in_range_q    <= 1'b0;
      overflow_q    <= 1'b0;
      width_valid_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      sat_q         <= sat_d;
      width_q       <= width_d;
      in_range_q    <= in_range_d;
      overflow_q    <= overflow_d;
      width_valid_q <= width_valid_d;
      busy_q        <= busy_d;
    end
  end

  assign width       = width_q;
  assign width_valid = width_valid_q;
  assign in_range    = in_range_q;
  assign overflow    = overflow_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_pulse_width_meter.sv
// Scoreboard bench for pulse_width_meter with CNT_W=8, TARGET=20, TOL=2
// (window 18..22). Expected reports are queued as pulses are issued; a
// monitor process pops and compares on every width_valid strobe.
module tb_pulse_width_meter;

  logic       clock;
  logic       reset_l;
  logic       pulse_in;
  logic       clear;
  logic [7:0] width;
  logic       width_valid;
  logic       in_range;
  logic       overflow;
  logic       busy;

  typedef struct packed {
    logic [7:0] w;
    logic       ir;
    logic       ov;
  } exp_t;

  exp_t exp_q[$];
  int   checks     = 0;
  int   failures   = 0;
  int   busy_total = 0;
  int   b0;

  pulse_width_meter #(
    .CNT_W  (8),
    .TARGET (20),
    .TOL    (2)
  ) dut (
    .clock       (clock),
    .reset_l     (reset_l),
    .pulse_in    (pulse_in),
    .clear       (clear),
    .width       (width),
    .width_valid (width_valid),
    .in_range    (in_range),
    .overflow    (overflow),
    .busy        (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic push(input int w, input int ir, input int ov);
    exp_t e;
    e.w  = 8'(w);
    e.ir = 1'(ir);
    e.ov = 1'(ov);
    exp_q.push_back(e);
  endtask

  // Pin high for hi sampled cycles, then low for lo cycles.
  task automatic send(input int hi, input int lo);
    pulse_in = 1'b1;
    repeat (hi) @(negedge clock);
    pulse_in = 1'b0;
    repeat (lo) @(negedge clock);
  endtask

  initial begin
    reset_l  = 1'b0;
    pulse_in = 1'b0;
    clear    = 1'b0;

    fork
      forever begin
        @(negedge clock);
        if (busy) busy_total++;
        if (width_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_strobe width=%0d in_range=%0d overflow=%0d",
                     width, in_range, overflow);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sb_width", int'(width), int'(e.w));
            chk("sb_in_range", int'(in_range), int'(e.ir));
            chk("sb_overflow", int'(overflow), int'(e.ov));
          end
        end
      end
    join_none

    // Reset state.
    repeat (3) @(negedge clock);
    chk("rst_width", int'(width), 0);
    chk("rst_valid", int'(width_valid), 0);
    chk("rst_in_range", int'(in_range), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_busy", int'(busy), 0);
    reset_l = 1'b1;
    repeat (3) @(negedge clock);

    // Test 1: single 20-cycle pulse, busy timing.
    b0 = busy_total;
    push(20, 1, 0);
    pulse_in = 1'b1;
    @(negedge clock);
    @(negedge clock);
    chk("t1_busy_before", int'(busy), 0);
    @(negedge clock);
    chk("t1_busy_start", int'(busy), 1);
    repeat (17) @(negedge clock);
    pulse_in = 1'b0;
    repeat (8) @(negedge clock);
    chk("t1_busy_cycles", busy_total - b0, 20);
    chk("t1_q_empty", exp_q.size(), 0);
    chk("t1_hold_width", int'(width), 20);
    chk("t1_hold_in_range", int'(in_range), 1);

    // Test 2: window edges.
    push(17, 0, 0); send(17, 8);
    push(18, 1, 0); send(18, 8);
    push(22, 1, 0); send(22, 8);
    push(23, 0, 0); send(23, 8);
    chk("t2_q_empty", exp_q.size(), 0);

    // Test 3: saturation, then recovery.
    push(255, 0, 1); send(300, 8);
    chk("t3_hold_overflow", int'(overflow), 1);
    push(20, 1, 0); send(20, 8);
    chk("t3_q_empty", exp_q.size(), 0);

    // Test 6: back-to-back pulses with a one-cycle gap.
    b0 = busy_total;
    push(20, 1, 0);
    push(20, 1, 0);
    send(20, 1);
    send(20, 8);
    chk("t6_busy_cycles", busy_total - b0, 40);
    chk("t6_q_empty", exp_q.size(), 0);

    // Test 4: pin high across reset release produces nothing.
    reset_l  = 1'b0;
    pulse_in = 1'b1;
    repeat (2) @(negedge clock);
    chk("t4_rst_width", int'(width), 0);
    chk("t4_rst_busy", int'(busy), 0);
    reset_l = 1'b1;
    b0 = busy_total;
    repeat (10) @(negedge clock);
    pulse_in = 1'b0;
    repeat (8) @(negedge clock);
    chk("t4_no_busy", busy_total - b0, 0);
    chk("t4_q_empty", exp_q.size(), 0);
    push(20, 1, 0); send(20, 8);
    chk("t4_after_q_empty", exp_q.size(), 0);

    // Test 5: clear mid-pulse aborts without a strobe.
    pulse_in = 1'b1;
    repeat (5) @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    chk("t5_busy", int'(busy), 0);
    chk("t5_width", int'(width), 0);
    chk("t5_in_range", int'(in_range), 0);
    chk("t5_overflow", int'(overflow), 0);
    repeat (15) @(negedge clock);
    pulse_in = 1'b0;
    repeat (8) @(negedge clock);
    chk("t5_q_empty", exp_q.size(), 0);
    push(18, 1, 0); send(18, 8);
    chk("t5_after_q_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
